// File: rtl/spi_regbank_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_regbank_if
// Brief    : Parallel write/read bus between the SPI slave and the register bank.
// Revision : 1.0
// ============================================================================
interface spi_regbank_if;
    logic       spien;
    logic       wrt;
    logic [3:0] addr;
    logic [7:0] wrtdata;
    logic [7:0] rddata;

    modport master (
        output spien,
        output wrt,
        output addr,
        output wrtdata,
        input  rddata
    );

    modport slave (
        input  spien,
        input  wrt,
        input  addr,
        input  wrtdata,
        output rddata
    );
endinterface
`default_nettype wire

// File: rtl/spi_regbank.sv
`default_nettype none
// ============================================================================
// Module   : spi_regbank
// Brief    : 16 x 8 register map committing SPI-slave writes in the clk domain.
// Revision : 1.0
// ============================================================================
module spi_regbank #(
    parameter logic [7:0] ID = 8'hA5
) (
    input  logic          clk,
    input  logic          reset,
    spi_regbank_if.slave  bus,
    output logic [95:0]   ctrl,
    input  logic [23:0]   status,
    output logic          wrstb,
    output logic [3:0]    wraddr
);

    localparam logic [3:0] c_FIRST_STATUS = 4'hC;

    logic       wrt_s1_q,   wrt_s1_d;
    logic       wrt_s2_q,   wrt_s2_d;
    logic       wrt_s3_q,   wrt_s3_d;
    logic       spien_s1_q, spien_s1_d;
    logic       spien_s2_q, spien_s2_d;
    logic [7:0] ctrl_q [0:11];
    logic [7:0] ctrl_d [0:11];
    logic [7:0] rddata_q,   rddata_d;
    logic       wrstb_q,    wrstb_d;
    logic [3:0] wraddr_q,   wraddr_d;
    logic       w_commit;

    // addr/wrtdata are quiescent when wrt falls with SS still high, so they
    // are sampled directly; requiring both SS stages high rejects aborts.
    always_comb begin
        wrt_s1_d   = bus.wrt;
        wrt_s2_d   = wrt_s1_q;
        wrt_s3_d   = wrt_s2_q;
        spien_s1_d = bus.spien;
        spien_s2_d = spien_s1_q;

        w_commit = ~wrt_s2_q & wrt_s3_q & spien_s1_q & spien_s2_q;

        ctrl_d   = ctrl_q;
        wrstb_d  = w_commit;
        wraddr_d = wraddr_q;
        if (w_commit) begin
            wraddr_d = bus.addr;
            if (bus.addr < c_FIRST_STATUS) begin
                ctrl_d[bus.addr] = bus.wrtdata;
            end
        end

        case (bus.addr)
            4'hC:    rddata_d = status[7:0];
            4'hD:    rddata_d = status[15:8];
            4'hE:    rddata_d = status[23:16];
            4'hF:    rddata_d = ID;
            default: rddata_d = ctrl_q[bus.addr];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrt_s1_q   <= 1'b0;
            wrt_s2_q   <= 1'b0;
            wrt_s3_q   <= 1'b0;
            spien_s1_q <= 1'b0;
            spien_s2_q <= 1'b0;
            for (int i = 0; i < 12; i++) begin
                ctrl_q[i] <= 8'h00;
            end
            rddata_q   <= 8'h00;
            wrstb_q    <= 1'b0;
            wraddr_q   <= 4'h0;
        end else begin
            wrt_s1_q   <= wrt_s1_d;
            wrt_s2_q   <= wrt_s2_d;
            wrt_s3_q   <= wrt_s3_d;
            spien_s1_q <= spien_s1_d;
            spien_s2_q <= spien_s2_d;
            ctrl_q     <= ctrl_d;
            rddata_q   <= rddata_d;
            wrstb_q    <= wrstb_d;
            wraddr_q   <= wraddr_d;
        end
    end

    for (genvar g = 0; g < 12; g++) begin : g_ctrl
        assign ctrl[8*g +: 8] = ctrl_q[g];
    end

    assign bus.rddata = rddata_q;
    assign wrstb      = wrstb_q;
    assign wraddr     = wraddr_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_regbank.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_regbank
// Brief    : Directed bench for spi_regbank with hand-computed expectations.
// Revision : 1.0
// ============================================================================
module tb_spi_regbank;

    logic        clk = 1'b0;
    logic        reset;
    logic [95:0] ctrl;
    logic [23:0] status;
    logic        wrstb;
    logic [3:0]  wraddr;

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int stb_cnt  = 0;
    logic [95:0] exp_ctrl;

    spi_regbank_if bus ();

    spi_regbank #(.ID(8'hA5)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus.slave),
        .ctrl   (ctrl),
        .status (status),
        .wrstb  (wrstb),
        .wraddr (wraddr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (wrstb) stb_cnt++;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        vec_cnt++;
        assert (obs === expv) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // SCLK = clk/8. Address bits shift on SCLK edges 2..5, data on 9..16.
    // With stop_edge == 16 the task returns right after wrt falls; otherwise
    // SS and wrt drop after stop_edge edges (skew 0: together, 1: wrt first,
    // 2: SS first) and the bus is left idle.
    task automatic spi_write(input logic [3:0] a, input logic [7:0] d,
                             input int stop_edge, input int skew);
        logic [3:0] ash;
        logic [7:0] dsh;
        ash = a;
        dsh = d;
        bus.spien = 1'b1;
        repeat (4) tick();
        for (int e = 1; e <= stop_edge; e++) begin
            if (e == 1) bus.wrt = 1'b1;
            if (e >= 2 && e <= 5) begin
                bus.addr = {bus.addr[2:0], ash[3]};
                ash = ash << 1;
            end
            if (e >= 9) begin
                bus.wrtdata = {bus.wrtdata[6:0], dsh[7]};
                dsh = dsh << 1;
            end
            if (e == 16) bus.wrt = 1'b0;
            else repeat (8) tick();
        end
        if (stop_edge < 16) begin
            case (skew)
                0: begin bus.wrt = 1'b0; bus.spien = 1'b0; end
                1: begin bus.wrt = 1'b0; tick(); bus.spien = 1'b0; end
                default: begin bus.spien = 1'b0; tick(); bus.wrt = 1'b0; end
            endcase
            repeat (8) tick();
        end
    endtask

    task automatic spi_end();
        bus.spien = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        reset       = 1'b1;
        status      = 24'h123456;
        bus.spien   = 1'b1;
        bus.wrt     = 1'b1;
        bus.addr    = 4'h5;
        bus.wrtdata = 8'h3C;
        exp_ctrl    = '0;

        // Reset held with wrt/SS high: no strobe, all outputs zero
        tick(); chk("rst_wrstb_c1", wrstb, 0);
        tick(); chk("rst_wrstb_c2", wrstb, 0);
        chk("rst_ctrl",   ctrl, 0);
        chk("rst_rddata", bus.rddata, 0);
        chk("rst_wraddr", wraddr, 0);

        // Release with wrt still high: chain refills, later fall commits
        reset = 1'b0;
        repeat (3) tick();
        chk("refill_nostb", stb_cnt, 0);
        bus.wrt = 1'b0;
        tick(); tick();
        chk("refill_e1_wrstb", wrstb, 0);
        tick();
        exp_ctrl[47:40] = 8'h3C;
        chk("refill_ctrl",   ctrl, exp_ctrl);
        chk("refill_wrstb",  wrstb, 1);
        chk("refill_wraddr", wraddr, 4'h5);
        spi_end();
        chk("refill_stb_cnt", stb_cnt, 1);

        // Full write 0x3 <= 0x5C with latency checks
        stb_cnt = 0;
        spi_write(4'h3, 8'h5C, 16, 0);
        tick();
        chk("wr_e0_ctrl",  ctrl, exp_ctrl);
        chk("wr_e0_wrstb", wrstb, 0);
        tick();
        chk("wr_e1_ctrl",  ctrl, exp_ctrl);
        chk("wr_e1_wrstb", wrstb, 0);
        tick();
        exp_ctrl[31:24] = 8'h5C;
        chk("wr_e2_ctrl",   ctrl, exp_ctrl);
        chk("wr_e2_wrstb",  wrstb, 1);
        chk("wr_e2_wraddr", wraddr, 4'h3);
        tick();
        chk("wr_e3_wrstb",  wrstb, 0);
        chk("wr_e3_rddata", bus.rddata, 8'h5C);
        spi_end();
        chk("wr_stb_cnt", stb_cnt, 1);

        // Aborted writes to 0x1 after 12 SCLK edges, three SS/wrt phasings
        for (int s = 0; s < 3; s++) begin
            stb_cnt = 0;
            spi_write(4'h1, 8'hE7, 12, s);
            chk($sformatf("abort%0d_ctrl", s), ctrl, exp_ctrl);
            chk($sformatf("abort%0d_stb", s), stb_cnt, 0);
            chk($sformatf("abort%0d_wraddr", s), wraddr, 4'h3);
        end

        // Read mux
        bus.addr = 4'hD; tick();
        chk("rd_status_d", bus.rddata, 8'h34);
        tick();
        chk("rd_status_d_hold", bus.rddata, 8'h34);
        bus.addr = 4'hF; tick();
        chk("rd_id", bus.rddata, 8'hA5);
        bus.addr = 4'h3; tick();
        chk("rd_ctrl3", bus.rddata, 8'h5C);
        bus.addr = 4'h5; tick();
        chk("rd_ctrl5", bus.rddata, 8'h3C);
        bus.addr = 4'h0; tick();
        chk("rd_ctrl0", bus.rddata, 8'h00);
        bus.addr = 4'hC; tick();
        chk("rd_status_c", bus.rddata, 8'h56);
        status = 24'h9A3456; tick();
        chk("rd_status_follow", bus.rddata, 8'h56);
        bus.addr = 4'hE; tick();
        chk("rd_status_e_new", bus.rddata, 8'h9A);
        status = 24'h123456;

        // Write to read-only 0xE: strobe and address only
        stb_cnt = 0;
        spi_write(4'hE, 8'hFF, 16, 0);
        repeat (3) tick();
        chk("ro_wrstb",  wrstb, 1);
        chk("ro_wraddr", wraddr, 4'hE);
        chk("ro_ctrl",   ctrl, exp_ctrl);
        tick();
        chk("ro_rddata", bus.rddata, 8'h12);
        spi_end();
        chk("ro_stb_cnt", stb_cnt, 1);

        // Reset lands in the commit cycle of a write to 0x0
        stb_cnt = 0;
        spi_write(4'h0, 8'h77, 16, 0);
        tick(); tick();
        reset = 1'b1;
        tick();
        exp_ctrl = '0;
        chk("coll_wrstb",  wrstb, 0);
        chk("coll_ctrl",   ctrl, exp_ctrl);
        chk("coll_wraddr", wraddr, 4'h0);
        reset = 1'b0;
        bus.spien = 1'b0;
        repeat (6) tick();
        chk("coll_stb_cnt", stb_cnt, 0);

        // Following write to 0x0 commits normally
        spi_write(4'h0, 8'h81, 16, 0);
        repeat (3) tick();
        exp_ctrl[7:0] = 8'h81;
        chk("post_ctrl",   ctrl, exp_ctrl);
        chk("post_wrstb",  wrstb, 1);
        chk("post_wraddr", wraddr, 4'h0);
        tick();
        chk("post_rddata", bus.rddata, 8'h81);
        spi_end();
        chk("post_stb_cnt", stb_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
